aes_stream_adapter: RTL and testbench



---
 rtl/aes_stream_adapter_if.sv | 33 +++
 rtl/aes_stream_adapter.sv | 227 ++++++++++++++++++++++
 tb/tb_aes_stream_adapter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_adapter_if.sv
// ----------------------------------------------------------------------------
// aes_stream_adapter_if
// Purpose : groups the two 32-bit valid/ready streams of aes_stream_adapter.
//           The upstream (s_*) stream carries plaintext/ciphertext words plus
//           the per-block direction flag; the downstream (m_*) stream carries
//           the result words with an end-of-block marker.
// Modports:
//   master : the environment side (drives s_* payload and m_ready)
//   slave  : the adapter side (drives s_ready and m_* payload)
// Signals :
//   s_valid / s_ready / s_data[31:0] / s_inv : input word stream
//   m_valid / m_ready / m_data[31:0] / m_last : output word stream
// ----------------------------------------------------------------------------
interface aes_stream_adapter_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_inv;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  modport master (
    output s_valid, s_data, s_inv, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_inv, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/aes_stream_adapter.sv
// ----------------------------------------------------------------------------
// aes_stream_adapter
// Purpose : sequential wrapper around a combinational AES-128 core. Collects
//           four big-endian 32-bit words into a 128-bit block, presents block,
//           key and direction to the core for SETTLE_CYCLES clocks (multicycle
//           path), captures the core output and replays it as four words.
// Ports   :
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   bus (slave)     : input word stream (s_*) and output word stream (m_*)
//   key_we, key_in  : key register load, honoured only while collecting
//   core_in         : block to the core Input
//   core_key        : key to the core CipherKey
//   core_inv        : direction to the core (1 = decrypt)
//   core_out        : core Output, sampled at the end of the settle window
//   busy            : high while settling or draining
// ----------------------------------------------------------------------------
module aes_stream_adapter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_stream_adapter_if.slave   bus,
  input  logic                  key_we,
  input  logic [127:0]          key_in,
  output logic [127:0]          core_in,
  output logic [127:0]          core_key,
  output logic                  core_inv,
  input  logic [127:0]          core_out,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Value of settle_cnt on the edge that captures core_out.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES) - 4'd1;

  state_t         state_r,      state_nxt;
  logic [1:0]     word_cnt_r,   word_cnt_nxt;
  logic [1:0]     out_cnt_r,    out_cnt_nxt;
  logic [3:0]     settle_cnt_r, settle_cnt_nxt;
  logic [127:0]   block_r,      block_nxt;
  logic [127:0]   key_r,        key_nxt;
  logic           inv_r,        inv_nxt;
  logic [127:0]   result_r,     result_nxt;

  // Stream outputs are registered, decoded from the next state.
  logic           s_ready_r,    s_ready_nxt;
  logic           m_valid_r,    m_valid_nxt;
  logic           m_last_r,     m_last_nxt;
  logic [31:0]    m_data_r,     m_data_nxt;
  logic           busy_r,       busy_nxt;

  logic           s_hs_s;

  // Big-endian word select: index 0 is bits [127:96].
  function automatic logic [31:0] word_sel(input logic [127:0] blk,
                                           input logic [1:0]   idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      2'd3:    w = blk[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Big-endian word insert: index 0 writes bits [127:96].
  function automatic logic [127:0] word_put(input logic [127:0] blk,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] b;
    b = blk;
    case (idx)
      2'd0:    b[127:96] = w;
      2'd1:    b[95:64]  = w;
      2'd2:    b[63:32]  = w;
      2'd3:    b[31:0]   = w;
      default: b         = blk;
    endcase
    return b;
  endfunction

  // Next-state, datapath and output decode for the collect/settle/drain FSM.
  always_comb begin
    state_nxt      = state_r;
    word_cnt_nxt   = word_cnt_r;
    out_cnt_nxt    = out_cnt_r;
    settle_cnt_nxt = settle_cnt_r;
    block_nxt      = block_r;
    key_nxt        = key_r;
    inv_nxt        = inv_r;
    result_nxt     = result_r;
    s_hs_s         = bus.s_valid & s_ready_r;

    case (state_r)
      ST_COLLECT: begin
        // A key load may share the edge with a word handshake.
        if (key_we) begin
          key_nxt = key_in;
        end else begin
          key_nxt = key_r;
        end
        if (s_hs_s) begin
          block_nxt = word_put(block_r, word_cnt_r, bus.s_data);
          // Direction belongs to the block and is taken from word 0 only.
          if (word_cnt_r == 2'd0) begin
            inv_nxt = bus.s_inv;
          end else begin
            inv_nxt = inv_r;
          end
          if (word_cnt_r == 2'd3) begin
            word_cnt_nxt   = 2'd0;
            settle_cnt_nxt = 4'd0;
            state_nxt      = ST_SETTLE;
          end else begin
            word_cnt_nxt   = word_cnt_r + 2'd1;
            settle_cnt_nxt = settle_cnt_r;
            state_nxt      = ST_COLLECT;
          end
        end else begin
          block_nxt    = block_r;
          inv_nxt      = inv_r;
          word_cnt_nxt = word_cnt_r;
          state_nxt    = ST_COLLECT;
        end
      end

      ST_SETTLE: begin
        // core_in/core_key/core_inv are frozen here; the core path has
        // SETTLE_CYCLES clocks to resolve before core_out is captured.
        settle_cnt_nxt = settle_cnt_r + 4'd1;
        if (settle_cnt_r == SETTLE_LAST) begin
          result_nxt  = core_out;
          out_cnt_nxt = 2'd0;
          state_nxt   = ST_DRAIN;
        end else begin
          result_nxt  = result_r;
          out_cnt_nxt = out_cnt_r;
          state_nxt   = ST_SETTLE;
        end
      end

      ST_DRAIN: begin
        if (bus.m_ready) begin
          out_cnt_nxt = out_cnt_r + 2'd1;
          if (out_cnt_r == 2'd3) begin
            state_nxt = ST_COLLECT;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          out_cnt_nxt = out_cnt_r;
          state_nxt   = ST_DRAIN;
        end
      end

      default: begin
        // Unreachable encoding: recover to an idle, empty collector.
        state_nxt      = ST_COLLECT;
        word_cnt_nxt   = 2'd0;
        out_cnt_nxt    = 2'd0;
        settle_cnt_nxt = 4'd0;
      end
    endcase

    s_ready_nxt = (state_nxt == ST_COLLECT);
    m_valid_nxt = (state_nxt == ST_DRAIN);
    busy_nxt    = (state_nxt != ST_COLLECT);
    m_last_nxt  = (state_nxt == ST_DRAIN) && (out_cnt_nxt == 2'd3);
    // result_nxt already holds core_out on the capture edge, so word 0 is
    // available in the very first DRAIN cycle.
    if (state_nxt == ST_DRAIN) begin
      m_data_nxt = word_sel(result_nxt, out_cnt_nxt);
    end else begin
      m_data_nxt = 32'h0000_0000;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_COLLECT;
      word_cnt_r   <= 2'd0;
      out_cnt_r    <= 2'd0;
      settle_cnt_r <= 4'd0;
      block_r      <= 128'h0;
      key_r        <= 128'h0;
      inv_r        <= 1'b0;
      result_r     <= 128'h0;
      s_ready_r    <= 1'b1;
      m_valid_r    <= 1'b0;
      m_last_r     <= 1'b0;
      m_data_r     <= 32'h0000_0000;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      word_cnt_r   <= word_cnt_nxt;
      out_cnt_r    <= out_cnt_nxt;
      settle_cnt_r <= settle_cnt_nxt;
      block_r      <= block_nxt;
      key_r        <= key_nxt;
      inv_r        <= inv_nxt;
      result_r     <= result_nxt;
      s_ready_r    <= s_ready_nxt;
      m_valid_r    <= m_valid_nxt;
      m_last_r     <= m_last_nxt;
      m_data_r     <= m_data_nxt;
      busy_r       <= busy_nxt;
    end
  end

  assign bus.s_ready = s_ready_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_last  = m_last_r;
  assign bus.m_data  = m_data_r;
  assign busy        = busy_r;
  assign core_in     = block_r;
  assign core_key    = key_r;
  assign core_inv    = inv_r;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// ----------------------------------------------------------------------------
// tb_aes_stream_adapter
// Directed bench for aes_stream_adapter. Three instances (SETTLE_CYCLES = 2,
// 1, 5) share the stimulus; sel routes stimulus to and observation from one
// instance. Each instance is closed by a stand-in core that returns the
// FIPS-197 C.1 vectors for the known key and a simple keyed transform
// otherwise.
// ----------------------------------------------------------------------------
module tb_aes_stream_adapter;

  localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2  = 128'hdeadbeefcafef00d0badf00d12345678;
  localparam logic [127:0] K3  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   sel;
  logic         s_valid;
  logic [31:0]  s_data;
  logic         s_inv;
  logic         m_ready;
  logic         key_we;
  logic [127:0] key_in;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in AES core.
  function automatic logic [127:0] core_model(input logic [127:0] din,
                                              input logic [127:0] key,
                                              input logic         inv);
    if (!inv && din == PT && key == K)      return CT;
    else if (inv && din == CT && key == K)  return PT;
    else if (inv)                           return ~({din[63:0], din[127:64]} ^ key);
    else                                    return {din[119:0], din[127:120]} ^ key;
  endfunction

  aes_stream_adapter_if bus0();
  aes_stream_adapter_if bus1();
  aes_stream_adapter_if bus2();

  logic [127:0] ci0, ck0, co0, ci1, ck1, co1, ci2, ck2, co2;
  logic         cv0, cv1, cv2, busy0, busy1, busy2;

  assign bus0.s_valid = s_valid & (sel == 2'd0);
  assign bus1.s_valid = s_valid & (sel == 2'd1);
  assign bus2.s_valid = s_valid & (sel == 2'd2);
  assign bus0.m_ready = m_ready & (sel == 2'd0);
  assign bus1.m_ready = m_ready & (sel == 2'd1);
  assign bus2.m_ready = m_ready & (sel == 2'd2);
  assign bus0.s_data  = s_data;
  assign bus1.s_data  = s_data;
  assign bus2.s_data  = s_data;
  assign bus0.s_inv   = s_inv;
  assign bus1.s_inv   = s_inv;
  assign bus2.s_inv   = s_inv;
  assign co0 = core_model(ci0, ck0, cv0);
  assign co1 = core_model(ci1, ck1, cv1);
  assign co2 = core_model(ci2, ck2, cv2);

  aes_stream_adapter #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .key_we(key_we & (sel == 2'd0)),
    .key_in(key_in), .core_in(ci0), .core_key(ck0), .core_inv(cv0),
    .core_out(co0), .busy(busy0));
  aes_stream_adapter #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .key_we(key_we & (sel == 2'd1)),
    .key_in(key_in), .core_in(ci1), .core_key(ck1), .core_inv(cv1),
    .core_out(co1), .busy(busy1));
  aes_stream_adapter #(.SETTLE_CYCLES(5)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .key_we(key_we & (sel == 2'd2)),
    .key_in(key_in), .core_in(ci2), .core_key(ck2), .core_inv(cv2),
    .core_out(co2), .busy(busy2));

  logic         s_ready_o, m_valid_o, m_last_o, busy_o, core_inv_o;
  logic [31:0]  m_data_o;
  logic [127:0] core_in_o, core_key_o;

  always_comb begin
    case (sel)
      2'd1: begin
        s_ready_o = bus1.s_ready; m_valid_o = bus1.m_valid; m_last_o = bus1.m_last;
        m_data_o = bus1.m_data; busy_o = busy1; core_in_o = ci1; core_key_o = ck1;
        core_inv_o = cv1;
      end
      2'd2: begin
        s_ready_o = bus2.s_ready; m_valid_o = bus2.m_valid; m_last_o = bus2.m_last;
        m_data_o = bus2.m_data; busy_o = busy2; core_in_o = ci2; core_key_o = ck2;
        core_inv_o = cv2;
      end
      default: begin
        s_ready_o = bus0.s_ready; m_valid_o = bus0.m_valid; m_last_o = bus0.m_last;
        m_data_o = bus0.m_data; busy_o = busy0; core_in_o = ci0; core_key_o = ck0;
        core_inv_o = cv0;
      end
    endcase
  end

  // ---------------- stimulus helpers (no comparisons) ----------------------
  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; key_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k; key_we = 1'b1;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] blk, input int nw,
                            input logic inv0, input logic inv_rest,
                            output logic ok);
    int n;
    ok = 1'b1;
    for (int i = 0; i < nw; i++) begin
      s_valid = 1'b1;
      s_data  = blk[127 - 32*i -: 32];
      s_inv   = (i == 0) ? inv0 : inv_rest;
      n = 0;
      while (!s_ready_o && n < 100) begin @(negedge clk); n++; end
      if (!s_ready_o) ok = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0; s_data = 32'h0; s_inv = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid_o && n < 100) begin @(negedge clk); n++; end
  endtask

  task automatic recv_block(output logic [127:0] blk, output logic [3:0] lasts,
                            output logic ok);
    int n;
    ok = 1'b1; blk = 128'h0; lasts = 4'h0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!m_valid_o && n < 100) begin @(negedge clk); n++; end
      if (!m_valid_o) ok = 1'b0;
      blk[127 - 32*i -: 32] = m_data_o;
      lasts[i] = m_last_o;
      @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    sel = 2'd0;
    do_reset();
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready_o); end
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid_o); end
    checks++; if (m_last_o !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b exp=0", m_last_o); end
    checks++; if (m_data_o !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (core_in_o !== 128'h0) begin failures++; $display("FAIL reset_core_in got=%h exp=0", core_in_o); end
    checks++; if (core_key_o !== 128'h0) begin failures++; $display("FAIL reset_core_key got=%h exp=0", core_key_o); end
    checks++; if (core_inv_o !== 1'b0) begin failures++; $display("FAIL reset_core_inv got=%b exp=0", core_inv_o); end
  endtask

  task automatic test_encrypt();
    logic ok; int n; logic [127:0] blk; logic [3:0] lasts;
    load_key(K);
    send_words(PT, 4, 1'b0, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL enc_send_timeout got=%b exp=1", ok); end
    wait_valid(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL enc_latency got=%0d exp=2", n); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL enc_busy got=%b exp=1", busy_o); end
    checks++; if (s_ready_o !== 1'b0) begin failures++; $display("FAIL enc_s_ready got=%b exp=0", s_ready_o); end
    recv_block(blk, lasts, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL enc_recv_timeout got=%b exp=1", ok); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (blk[127 - 32*i -: 32] !== CT[127 - 32*i -: 32]) begin
        failures++; $display("FAIL enc_word%0d got=%h exp=%h", i, blk[127 - 32*i -: 32], CT[127 - 32*i -: 32]);
      end
    end
    checks++; if (lasts !== 4'b1000) begin failures++; $display("FAIL enc_m_last got=%b exp=1000", lasts); end
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL enc_ready_after got=%b exp=1", s_ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL enc_busy_after got=%b exp=0", busy_o); end
  endtask

  task automatic test_decrypt();
    logic ok; int n; logic [127:0] blk; logic [3:0] lasts;
    send_words(CT, 4, 1'b1, 1'b0, ok);
    checks++; if (core_inv_o !== 1'b1) begin failures++; $display("FAIL dec_core_inv got=%b exp=1", core_inv_o); end
    wait_valid(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL dec_latency got=%0d exp=2", n); end
    recv_block(blk, lasts, ok);
    checks++; if (blk !== PT) begin failures++; $display("FAIL dec_result got=%h exp=%h", blk, PT); end
    checks++; if (lasts !== 4'b1000) begin failures++; $display("FAIL dec_m_last got=%b exp=1000", lasts); end
  endtask

  task automatic test_backpressure();
    logic ok; int n; int bad; logic [127:0] blk; logic [3:0] lasts;
    m_ready = 1'b0;
    send_words(PT, 4, 1'b0, 1'b0, ok);
    wait_valid(n);
    s_valid = 1'b1; s_data = 32'hbad0bad0; s_inv = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_valid_o !== 1'b1 || m_data_o !== 32'h69c4e0d8 || s_ready_o !== 1'b0 || m_last_o !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold_unstable_cycles got=%0d exp=0", bad); end
    checks++; if (core_in_o !== PT) begin failures++; $display("FAIL bp_block_kept got=%h exp=%h", core_in_o, PT); end
    s_valid = 1'b0; s_data = 32'h0; s_inv = 1'b0;
    recv_block(blk, lasts, ok);
    checks++; if (blk !== CT) begin failures++; $display("FAIL bp_result got=%h exp=%h", blk, CT); end
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%b exp=1", s_ready_o); end
  endtask

  task automatic test_key_protect();
    logic ok; int n; logic [127:0] blk; logic [3:0] lasts;
    send_words(PT, 4, 1'b0, 1'b0, ok);
    load_key(K2);
    checks++; if (core_key_o !== K) begin failures++; $display("FAIL kp_settle_key got=%h exp=%h", core_key_o, K); end
    wait_valid(n);
    load_key(K2);
    checks++; if (core_key_o !== K) begin failures++; $display("FAIL kp_drain_key got=%h exp=%h", core_key_o, K); end
    recv_block(blk, lasts, ok);
    checks++; if (blk !== CT) begin failures++; $display("FAIL kp_result got=%h exp=%h", blk, CT); end
    load_key(K3);
    send_words(PT, 4, 1'b0, 1'b0, ok);
    wait_valid(n);
    recv_block(blk, lasts, ok);
    checks++; if (blk !== core_model(PT, K3, 1'b0)) begin
      failures++; $display("FAIL kp_next_key_result got=%h exp=%h", blk, core_model(PT, K3, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    logic ok; int n; logic [127:0] blk; logic [3:0] lasts;
    send_words(PT, 2, 1'b0, 1'b0, ok);
    do_reset();
    checks++; if (s_ready_o !== 1'b1 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
      failures++; $display("FAIL rm_partial ready/busy/valid got=%b%b%b exp=100", s_ready_o, busy_o, m_valid_o);
    end
    load_key(K);
    send_words(PT, 4, 1'b0, 1'b0, ok);
    wait_valid(n);
    do_reset();
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL rm_drain_m_valid got=%b exp=0", m_valid_o); end
    checks++; if (s_ready_o !== 1'b1) begin failures++; $display("FAIL rm_drain_s_ready got=%b exp=1", s_ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rm_drain_busy got=%b exp=0", busy_o); end
    checks++; if (core_key_o !== 128'h0) begin failures++; $display("FAIL rm_key_cleared got=%h exp=0", core_key_o); end
    load_key(K);
    send_words(PT, 4, 1'b0, 1'b0, ok);
    wait_valid(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL rm_latency got=%0d exp=2", n); end
    recv_block(blk, lasts, ok);
    checks++; if (blk !== CT) begin failures++; $display("FAIL rm_fresh_result got=%h exp=%h", blk, CT); end
  endtask

  task automatic test_back_to_back();
    logic ok; int n; int lat; logic [127:0] blk; logic [3:0] lasts;
    for (int j = 1; j <= 2; j++) begin
      sel = 2'(j);
      lat = (j == 1) ? 1 : 5;
      do_reset();
      load_key(K);
      send_words(PT, 4, 1'b0, 1'b0, ok);
      wait_valid(n);
      checks++; if (n !== lat) begin failures++; $display("FAIL b2b_lat1_s%0d got=%0d exp=%0d", lat, n, lat); end
      recv_block(blk, lasts, ok);
      checks++; if (blk !== CT) begin failures++; $display("FAIL b2b_res1_s%0d got=%h exp=%h", lat, blk, CT); end
      send_words(PT2, 4, 1'b0, 1'b0, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_send2_s%0d got=%b exp=1", lat, ok); end
      wait_valid(n);
      checks++; if (n !== lat) begin failures++; $display("FAIL b2b_lat2_s%0d got=%0d exp=%0d", lat, n, lat); end
      recv_block(blk, lasts, ok);
      checks++; if (blk !== core_model(PT2, K, 1'b0)) begin
        failures++; $display("FAIL b2b_res2_s%0d got=%h exp=%h", lat, blk, core_model(PT2, K, 1'b0));
      end
      checks++; if (lasts !== 4'b1000) begin failures++; $display("FAIL b2b_last_s%0d got=%b exp=1000", lat, lasts); end
    end
  endtask

  initial begin
    rst = 1'b1; sel = 2'd0; s_valid = 1'b0; s_data = 32'h0; s_inv = 1'b0;
    m_ready = 1'b0; key_we = 1'b0; key_in = 128'h0;
    @(negedge clk);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_key_protect();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
